// File: rtl/pe_array_acc.sv
// Signed multiply-reduce array with a three-register pipeline: multiply, reduce, then accumulate.
// Results accumulate per output channel across input-channel tiles and are held until downstream takes them.
module pe_array_acc #(
  parameter int IN_CH  = 8,
  parameter int OUT_CH = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  output logic                           i_ready,
  input  logic                           i_first,
  input  logic                           i_last,
  input  logic                           i_relu,
  input  logic [IN_CH*DATA_W-1:0]        i_ifmap,
  input  logic [OUT_CH*IN_CH*DATA_W-1:0] i_weight,
  input  logic [OUT_CH*ACC_W-1:0]        i_bias,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [OUT_CH*ACC_W-1:0]        o_ofmap
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(IN_CH);

  logic stall;

  logic                       s1_valid, s1_first, s1_last, s1_relu;
  logic [OUT_CH*ACC_W-1:0]    s1_bias;
  logic signed [PROD_W-1:0]   s1_prod [OUT_CH][IN_CH];
  logic signed [PROD_W-1:0]   prod    [OUT_CH][IN_CH];

  logic                       s2_valid, s2_first, s2_last, s2_relu;
  logic [OUT_CH*ACC_W-1:0]    s2_bias;
  logic signed [SUM_W-1:0]    s2_sum [OUT_CH];
  logic signed [SUM_W-1:0]    sum    [OUT_CH];

  logic signed [ACC_W-1:0]    acc [OUT_CH];
  logic signed [ACC_W-1:0]    res [OUT_CH];
  logic                       pkt_open;

  // Backpressure freezes the whole pipeline in the same cycle the output is refused.
  assign stall   = o_valid && !o_ready;
  assign i_ready = !rst && !stall;

  always_comb begin
    for (int o = 0; o < OUT_CH; o++) begin
      for (int i = 0; i < IN_CH; i++) begin
        prod[o][i] = PROD_W'($signed(i_ifmap[i*DATA_W +: DATA_W]))
                   * PROD_W'($signed(i_weight[(o*IN_CH+i)*DATA_W +: DATA_W]));
      end
    end
  end

  always_comb begin
    for (int o = 0; o < OUT_CH; o++) begin
      sum[o] = '0;
      for (int i = 0; i < IN_CH; i++) begin
        sum[o] = sum[o] + SUM_W'(s1_prod[o][i]);
      end
    end
  end

  // A beat that arrives with no packet open restarts from bias, so stray tiles never inherit stale sums.
  always_comb begin
    for (int o = 0; o < OUT_CH; o++) begin
      res[o] = ((s2_first || !pkt_open) ? s2_bias[o*ACC_W +: ACC_W] : acc[o])
             + ACC_W'(s2_sum[o]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
      s1_bias  <= '0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_relu  <= 1'b0;
      s2_bias  <= '0;
      pkt_open <= 1'b0;
      o_valid  <= 1'b0;
      o_ofmap  <= '0;
      for (int o = 0; o < OUT_CH; o++) begin
        for (int i = 0; i < IN_CH; i++) s1_prod[o][i] <= '0;
        s2_sum[o] <= '0;
        acc[o]    <= '0;
      end
    end else if (!stall) begin
      s1_valid <= i_valid;
      s1_first <= i_first;
      s1_last  <= i_last;
      s1_relu  <= i_relu;
      s1_bias  <= i_bias;
      s1_prod  <= prod;

      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_relu  <= s1_relu;
      s2_bias  <= s1_bias;
      s2_sum   <= sum;

      if (s2_valid) begin
        pkt_open <= !s2_last;
        for (int o = 0; o < OUT_CH; o++) acc[o] <= res[o];
      end

      // Not stalled means any pending result is being taken now, so o_valid only survives via a new result.
      if (s2_valid && s2_last) begin
        o_valid <= 1'b1;
        for (int o = 0; o < OUT_CH; o++) begin
          o_ofmap[o*ACC_W +: ACC_W] <= (s2_relu && res[o][ACC_W-1]) ? '0 : res[o];
        end
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_array_acc.sv
// Directed bench for pe_array_acc: a behavioural model feeds a scoreboard that checks every
// delivered result, on a 32-bit instance and a 16-bit instance that shows wrap-around.
module tb_pe_array_acc;

  localparam int IN_CH  = 8;
  localparam int OUT_CH = 8;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [OUT_CH*32-1:0] e32;
    logic [OUT_CH*16-1:0] e16;
  } exp_t;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           i_valid, i_first, i_last, i_relu, o_ready;
  logic [IN_CH*DATA_W-1:0]        i_ifmap;
  logic [OUT_CH*IN_CH*DATA_W-1:0] i_weight;
  logic [OUT_CH*32-1:0]           i_bias;
  logic [OUT_CH*16-1:0]           bias16;
  logic                           i_ready, o_valid, i_ready_w, o_valid_w;
  logic [OUT_CH*32-1:0]           o_ofmap;
  logic [OUT_CH*16-1:0]           o_ofmap_w;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q [$];
  logic [OUT_CH*32-1:0] got32 [$];
  logic [OUT_CH*16-1:0] got16 [$];

  bit      m_open;
  int      m_acc32 [OUT_CH];
  shortint m_acc16 [OUT_CH];
  int      m_s;
  bit      m_fresh;
  logic signed [7:0] m_a, m_b;
  exp_t    m_exp, m_pop;
  logic [OUT_CH*32-1:0] snap;

  always #5 clk = ~clk;

  always_comb begin
    for (int o = 0; o < OUT_CH; o++) bias16[o*16 +: 16] = i_bias[o*32 +: 16];
  end

  pe_array_acc #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .DATA_W(DATA_W), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .i_first(i_first), .i_last(i_last), .i_relu(i_relu),
    .i_ifmap(i_ifmap), .i_weight(i_weight), .i_bias(i_bias),
    .o_valid(o_valid), .o_ready(o_ready), .o_ofmap(o_ofmap)
  );

  pe_array_acc #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .DATA_W(DATA_W), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_w),
    .i_first(i_first), .i_last(i_last), .i_relu(i_relu),
    .i_ifmap(i_ifmap), .i_weight(i_weight), .i_bias(bias16),
    .o_valid(o_valid_w), .o_ready(o_ready), .o_ofmap(o_ofmap_w)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [IN_CH*DATA_W-1:0] fill_ifmap(input logic [7:0] v);
    logic [IN_CH*DATA_W-1:0] r;
    for (int i = 0; i < IN_CH; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [OUT_CH*IN_CH*DATA_W-1:0] fill_weight(input logic [7:0] v, input bit ramp);
    logic [OUT_CH*IN_CH*DATA_W-1:0] r;
    for (int o = 0; o < OUT_CH; o++)
      for (int i = 0; i < IN_CH; i++) r[(o*IN_CH+i)*8 +: 8] = ramp ? 8'(o + 1) : v;
    return r;
  endfunction

  function automatic logic [OUT_CH*32-1:0] fill_bias(input int v);
    logic [OUT_CH*32-1:0] r;
    for (int o = 0; o < OUT_CH; o++) r[o*32 +: 32] = v;
    return r;
  endfunction

  // Waits (bounded) for the beat currently driven to be accepted, then leaves the bench just after that edge.
  task automatic waitAccept(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (i_ready) ok = 1'b1;
    end
    checkOutput({tag, "_accepted"}, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic first, input logic last, input logic relu,
                               input logic [IN_CH*DATA_W-1:0] ifm,
                               input logic [OUT_CH*IN_CH*DATA_W-1:0] wgt,
                               input logic [OUT_CH*32-1:0] bias);
    i_valid  = 1'b1;
    i_first  = first;
    i_last   = last;
    i_relu   = relu;
    i_ifmap  = ifm;
    i_weight = wgt;
    i_bias   = bias;
    waitAccept("beat");
    i_valid  = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !o_valid) ok = 1'b1;
    end
    checkOutput({tag, "_drained"}, 32'(ok), 32'd1);
  endtask

  task automatic checkResult(input string tag, input int idx, input int base, input int step);
    logic [OUT_CH*32-1:0] v;
    checkOutput({tag, "_present"}, 32'(got32.size() > idx), 32'd1);
    if (got32.size() > idx) begin
      v = got32[idx];
      for (int o = 0; o < OUT_CH; o++)
        checkOutput($sformatf("%s_ch%0d", tag, o), v[o*32 +: 32], base + step * (o + 1));
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle where all inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      m_open = 1'b0;
    end else begin
      if (o_valid && o_ready) begin
        checkOutput("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        checkOutput("sb_valid16", 32'(o_valid_w), 32'd1);
        if (sb_q.size() != 0) begin
          m_pop = sb_q.pop_front();
          for (int o = 0; o < OUT_CH; o++) begin
            checkOutput($sformatf("sb32_ch%0d", o), o_ofmap[o*32 +: 32], m_pop.e32[o*32 +: 32]);
            checkOutput($sformatf("sb16_ch%0d", o), {16'h0, o_ofmap_w[o*16 +: 16]},
                        {16'h0, m_pop.e16[o*16 +: 16]});
          end
        end
        got32.push_back(o_ofmap);
        got16.push_back(o_ofmap_w);
      end
      if (i_valid && i_ready) begin
        m_fresh = i_first || !m_open;
        for (int o = 0; o < OUT_CH; o++) begin
          m_s = 0;
          for (int i = 0; i < IN_CH; i++) begin
            m_a = i_ifmap[i*8 +: 8];
            m_b = i_weight[(o*IN_CH+i)*8 +: 8];
            m_s = m_s + int'(m_a) * int'(m_b);
          end
          m_acc32[o] = m_fresh ? int'(i_bias[o*32 +: 32]) + m_s : m_acc32[o] + m_s;
          m_acc16[o] = m_fresh ? shortint'(i_bias[o*32 +: 16]) + shortint'(m_s)
                               : m_acc16[o] + shortint'(m_s);
          m_exp.e32[o*32 +: 32] = (i_relu && m_acc32[o] < 0) ? 32'd0 : m_acc32[o];
          m_exp.e16[o*16 +: 16] = (i_relu && m_acc16[o] < 0) ? 16'd0 : m_acc16[o];
        end
        m_open = !i_last;
        if (i_last) sb_q.push_back(m_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; o_ready = 1'b1; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; i_relu = 1'b0;
    i_ifmap = '0; i_weight = '0; i_bias = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_o_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_i_ready", 32'(i_ready), 32'd0);
    for (int o = 0; o < OUT_CH; o++) checkOutput($sformatf("rst_ofmap_ch%0d", o), o_ofmap[o*32 +: 32], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_i_ready", 32'(i_ready), 32'd1);
    @(posedge clk); #1;

    // Single tile, also checks the three-stage latency from the accepting edge.
    $display("[TB] single-tile packet");
    got32.delete(); got16.delete();
    applyStimulus(1, 1, 0, fill_ifmap(8'd2), fill_weight(8'd0, 1'b1), fill_bias(100));
    @(negedge clk); checkOutput("lat_edge1", 32'(o_valid), 32'd0);
    @(negedge clk); checkOutput("lat_edge2", 32'(o_valid), 32'd0);
    @(negedge clk); checkOutput("lat_edge3", 32'(o_valid), 32'd1);
    waitDrain("single");
    checkResult("single", 0, 100, 16);

    $display("[TB] four-tile packets back-to-back");
    got32.delete(); got16.delete();
    applyStimulus(1, 0, 0, fill_ifmap(8'hFF), fill_weight(8'd3, 1'b0), fill_bias(0));
    applyStimulus(0, 0, 0, fill_ifmap(8'hFF), fill_weight(8'd3, 1'b0), fill_bias(0));
    applyStimulus(0, 0, 0, fill_ifmap(8'hFF), fill_weight(8'd3, 1'b0), fill_bias(0));
    applyStimulus(0, 1, 0, fill_ifmap(8'hFF), fill_weight(8'd3, 1'b0), fill_bias(0));
    applyStimulus(1, 0, 0, fill_ifmap(8'd1), fill_weight(8'd1, 1'b0), fill_bias(7));
    applyStimulus(0, 0, 0, fill_ifmap(8'd1), fill_weight(8'd1, 1'b0), fill_bias(0));
    applyStimulus(0, 0, 0, fill_ifmap(8'd1), fill_weight(8'd1, 1'b0), fill_bias(0));
    applyStimulus(0, 1, 0, fill_ifmap(8'd1), fill_weight(8'd1, 1'b0), fill_bias(0));
    waitDrain("multi");
    checkOutput("multi_count", 32'(got32.size()), 32'd2);
    checkResult("multi_neg", 0, -96, 0);
    checkResult("multi_second", 1, 39, 0);

    $display("[TB] relu handling");
    got32.delete(); got16.delete();
    for (int t = 0; t < 4; t++)
      applyStimulus(t == 0, t == 3, t == 3, fill_ifmap(8'hFF), fill_weight(8'd3, 1'b0), fill_bias(0));
    for (int t = 0; t < 4; t++)
      applyStimulus(t == 0, t == 3, t == 0, fill_ifmap(8'hFF), fill_weight(8'd3, 1'b0), fill_bias(0));
    applyStimulus(1, 1, 1, fill_ifmap(8'd2), fill_weight(8'd0, 1'b1), fill_bias(100));
    waitDrain("relu");
    checkResult("relu_last", 0, 0, 0);
    checkResult("relu_first_only", 1, -96, 0);
    checkResult("relu_positive", 2, 100, 16);

    $display("[TB] backpressure");
    got32.delete(); got16.delete();
    o_ready = 1'b0;
    applyStimulus(1, 1, 0, fill_ifmap(8'd1), fill_weight(8'd0, 1'b1), fill_bias(10));
    applyStimulus(1, 1, 0, fill_ifmap(8'd1), fill_weight(8'd0, 1'b1), fill_bias(20));
    applyStimulus(1, 1, 0, fill_ifmap(8'd1), fill_weight(8'd0, 1'b1), fill_bias(30));
    i_valid = 1'b1; i_first = 1'b1; i_last = 1'b1; i_relu = 1'b0;
    i_ifmap = fill_ifmap(8'd1); i_weight = fill_weight(8'd0, 1'b1); i_bias = fill_bias(40);
    @(negedge clk);
    checkOutput("stall_o_valid", 32'(o_valid), 32'd1);
    snap = o_ofmap;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_i_ready_%0d", c), 32'(i_ready), 32'd0);
      for (int o = 0; o < OUT_CH; o++)
        checkOutput($sformatf("stall_hold_%0d_ch%0d", c, o), o_ofmap[o*32 +: 32], snap[o*32 +: 32]);
    end
    @(posedge clk); #1;
    o_ready = 1'b1;
    waitAccept("stall_pending");
    i_valid = 1'b0;
    waitDrain("stall");
    checkOutput("stall_count", 32'(got32.size()), 32'd4);
    checkResult("stall_first", 0, 10, 8);
    checkResult("stall_last", 3, 40, 8);

    $display("[TB] reset mid-packet");
    got32.delete(); got16.delete();
    applyStimulus(1, 0, 0, fill_ifmap(8'hFF), fill_weight(8'd3, 1'b0), fill_bias(0));
    applyStimulus(0, 0, 0, fill_ifmap(8'hFF), fill_weight(8'd3, 1'b0), fill_bias(0));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_o_valid", 32'(o_valid), 32'd0);
    checkOutput("midrst_i_ready", 32'(i_ready), 32'd0);
    for (int o = 0; o < OUT_CH; o++)
      checkOutput($sformatf("midrst_ofmap_ch%0d", o), o_ofmap[o*32 +: 32], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 1, 0, fill_ifmap(8'd0), fill_weight(8'd3, 1'b0), fill_bias(5));
    waitDrain("midrst");
    checkResult("midrst_fresh", 0, 5, 0);

    $display("[TB] extremes");
    got32.delete(); got16.delete();
    applyStimulus(1, 1, 0, fill_ifmap(8'h80), fill_weight(8'h80, 1'b0), fill_bias(0));
    waitDrain("extreme");
    checkResult("extreme32", 0, 131072, 0);
    checkOutput("extreme16_present", 32'(got16.size()), 32'd1);
    if (got16.size() == 1) begin
      snap[OUT_CH*16-1:0] = got16[0];
      for (int o = 0; o < OUT_CH; o++)
        checkOutput($sformatf("extreme16_ch%0d", o), {16'h0, snap[o*16 +: 16]}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
